// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the iterative RV64M multiplier.
package mul_pkg;

  // funct3[1:0] encoding of the M-extension multiply family
  typedef enum logic [1:0] {
    MUL_MUL = 2'b00,
    MUL_H   = 2'b01,
    MUL_HSU = 2'b10,
    MUL_HU  = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_MULT = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mul_state_e;

  localparam int XLEN_DEF     = 64;
  localparam int SUB_SIZE_DEF = 16;
  localparam int N            = XLEN_DEF / SUB_SIZE_DEF;
  localparam int N_W          = N / 2;

  // Number of sub_mul-sized chunks per operand
  function automatic int chunk_count(input int xlen, input int sub);
    return xlen / sub;
  endfunction

endpackage

// File: rtl/sub_mul.sv
// Combinational unsigned mul_size x mul_size multiplier slice.
module sub_mul #(
  parameter int mul_size = 16,
  parameter int use_dsp  = 0
) (
  input  logic [mul_size-1:0]   a_i,
  input  logic [mul_size-1:0]   b_i,
  output logic [2*mul_size-1:0] p_o
);

  if (use_dsp != 0) begin : g_dsp
    // Plain product so the tool can map it onto a hard multiplier
    assign p_o = (2*mul_size)'(a_i) * (2*mul_size)'(b_i);
  end else begin : g_shift_add
    // Explicit shift-add array kept in fabric logic
    always_comb begin
      p_o = '0;
      for (int k = 0; k < mul_size; k++) begin
        p_o = p_o + (b_i[k] ? ((2*mul_size)'(a_i) << k) : '0);
      end
    end
  end

endmodule

// File: rtl/iter_mul.sv
// Iterative RV64M multiplier: magnitude prep, chunked accumulate, sign fix.
module iter_mul
  import mul_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int SUB_SIZE = 16,
  parameter int USE_DSP  = 0,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NC  = chunk_count(XLEN, SUB_SIZE);
  localparam int NCW = NC / 2;
  localparam int CW  = (NC > 1) ? $clog2(NC) : 1;
  localparam int AW  = 2 * XLEN;
  localparam logic [XLEN-1:0] W_MASK = XLEN'(32'hFFFF_FFFF);

  mul_state_e         state_q;
  mul_op_e            op_q;
  logic               word_q;
  logic [TAG_W-1:0]   tag_q;
  logic [XLEN-1:0]    a_q, b_q;
  logic               neg_q;
  logic [AW-1:0]      acc_q;
  logic [CW-1:0]      ci_q, cj_q;
  logic               out_valid_q;
  logic [XLEN-1:0]    out_result_q;
  logic [TAG_W-1:0]   out_tag_q;

  logic               sa_s, sb_s;
  logic [XLEN-1:0]    a_ext_s, b_ext_s, a_mag_s, b_mag_s;
  logic [SUB_SIZE-1:0]   chunk_a_s, chunk_b_s;
  logic [2*SUB_SIZE-1:0] prod_s;
  logic [31:0]        sh_s;
  logic [AW-1:0]      acc_d, acc_fix_s;
  logic [XLEN-1:0]    res_s;
  logic [CW-1:0]      lim_s;

  // Effective operand signs and magnitudes from the latched request
  always_comb begin
    sa_s    = !word_q && ((op_q == MUL_H) || (op_q == MUL_HSU)) && a_q[XLEN-1];
    sb_s    = !word_q && (op_q == MUL_H) && b_q[XLEN-1];
    a_ext_s = word_q ? (a_q & W_MASK) : a_q;
    b_ext_s = word_q ? (b_q & W_MASK) : b_q;
    a_mag_s = sa_s ? (~a_ext_s + XLEN'(1)) : a_ext_s;
    b_mag_s = sb_s ? (~b_ext_s + XLEN'(1)) : b_ext_s;
  end

  // Chunk selection and shifted partial-product accumulation
  always_comb begin
    chunk_a_s = a_q[int'(ci_q)*SUB_SIZE +: SUB_SIZE];
    chunk_b_s = b_q[int'(cj_q)*SUB_SIZE +: SUB_SIZE];
    sh_s      = 32'((int'(ci_q) + int'(cj_q)) * SUB_SIZE);
    acc_d     = acc_q + (AW'(prod_s) << sh_s);
    lim_s     = word_q ? CW'(NCW - 1) : CW'(NC - 1);
  end

  // Sign correction and result-half selection
  always_comb begin
    acc_fix_s = neg_q ? (~acc_q + AW'(1)) : acc_q;
    if (word_q) begin
      res_s = {{(XLEN-32){acc_fix_s[31]}}, acc_fix_s[31:0]};
    end else begin
      case (op_q)
        MUL_MUL: res_s = acc_fix_s[XLEN-1:0];
        default: res_s = acc_fix_s[AW-1:XLEN];
      endcase
    end
  end

  sub_mul #(.mul_size(SUB_SIZE), .use_dsp(USE_DSP)) u_sub_mul (
    .a_i (chunk_a_s),
    .b_i (chunk_b_s),
    .p_o (prod_s)
  );

  // Control FSM with all datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= MUL_MUL;
      word_q       <= 1'b0;
      tag_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      neg_q        <= 1'b0;
      acc_q        <= '0;
      ci_q         <= '0;
      cj_q         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q    <= mul_op_e'(in_op);
            word_q  <= in_word;
            tag_q   <= in_tag;
            a_q     <= in_a;
            b_q     <= in_b;
            state_q <= ST_PREP;
          end
        end
        ST_PREP: begin
          a_q     <= a_mag_s;
          b_q     <= b_mag_s;
          neg_q   <= sa_s ^ sb_s;
          acc_q   <= '0;
          ci_q    <= '0;
          cj_q    <= '0;
          state_q <= ST_MULT;
        end
        ST_MULT: begin
          acc_q <= acc_d;
          if (cj_q == lim_s) begin
            cj_q <= '0;
            if (ci_q == lim_s) begin
              ci_q    <= '0;
              state_q <= ST_FIX;
            end else begin
              ci_q <= ci_q + CW'(1);
            end
          end else begin
            cj_q <= cj_q + CW'(1);
          end
        end
        ST_FIX: begin
          acc_q        <= acc_fix_s;
          out_result_q <= res_s;
          out_tag_q    <= tag_q;
          out_valid_q  <= 1'b1;
          state_q      <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: doc/iter_mul.md
# iter_mul

Iterative RV64M integer multiplier for the stage-3 functional-unit cluster. It decodes MUL/MULH/MULHSU/MULHU/MULW and converts operands to magnitudes. It then streams operand chunk pairs through a single `sub_mul` instance and accumulates the shifted partial products into a 2·XLEN register. Finally it applies sign correction and returns the selected result half to writeback over a valid/ready handshake.

## Interface
- `XLEN`, 64: operand width.
- `SUB_SIZE`, 16: `sub_mul` width. XLEN/2 must be divisible by SUB_SIZE. N = XLEN/SUB_SIZE.
- `USE_DSP`, 0: forwarded to `sub_mul`.
- `TAG_W`, 5: destination tag width.

Clock and reset: one clock. Reset is synchronous and active-high.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: kill in-flight op (pipeline squash).
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit idle, request may be accepted.
- `in_op` in 2: mul_op_e: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `in_word` in 1: MULW. `in_op` is ignored when set.
- `in_a`, `in_b` in XLEN: rs1, rs2 values.
- `in_tag` in TAG_W: destination tag.
- `out_valid` out 1: result valid.
- `out_ready` in 1: writeback accepts.
- `out_result` out XLEN: result.
- `out_tag` out TAG_W: tag of the result.

## Operation
- FSM states: IDLE, PREP, MULT, FIX, DONE.
- **IDLE**
  - `in_ready`=1 only in IDLE.
  - On `in_valid`&&`in_ready`: latch op, word, tag, a, b; go to PREP.
- **PREP**
  - Effective signs: a is signed for MULH and MULHSU; b is signed for MULH only.
  - MUL and MULW are treated as unsigned.
  - Register |a|, |b| as XLEN-bit unsigned values. -2^63 gives magnitude 2^63, no overflow.
  - neg = sa^sb.
  - MULW zeroes operand bits [XLEN-1:32].
  - Clear the accumulator and counter; go to MULT.
- **MULT**
  - Counter k walks chunk pairs (i,j): i is the outer a-chunk index, j the inner b-chunk index.
  - Ranges are 0..N-1 each, or 0..N/2-1 for MULW.
  - Each cycle: acc += zero-extended `sub_mul`(a_i, b_j) << SUB_SIZE·(i+j), modulo 2^(2·XLEN).
  - After the last pair, go to FIX.
- **FIX**: if neg, acc = ~acc + 1 (full 2·XLEN). Go to DONE.
- **DONE**
  - `out_valid`=1.
  - `out_result` selection:
    - MUL: acc[XLEN-1:0].
    - MULH, MULHSU, MULHU: acc[2·XLEN-1:XLEN].
    - MULW: sign-extend acc[31:0].
  - Hold `out_result` and `out_tag` stable until `out_valid`&&`out_ready`, then go to IDLE.
- **flush**: from any state, the next state is IDLE. `out_valid` drops next cycle and no result is produced. `flush` wins over `in_valid` in IDLE.
- **rst**: same effect as flush. Reset values:
  - state=IDLE.
  - `out_valid`=0.
  - `out_result`=0.
  - `out_tag`=0.
  - acc=0, counter=0.
  - `in_ready`=0 during the reset cycle and 1 from the following cycle.

## Timing
- Cycle 0 is the accept cycle. PREP is cycle 1, MULT covers cycles 2..P+1, FIX is cycle P+2, and `out_valid` rises in cycle P+3.
- P = N² for normal ops (16 at defaults, latency 19).
- P = (N/2)² for MULW (4 at defaults, latency 7).
- No new accept while busy. After the output handshake in cycle t, `in_ready`=1 in cycle t+1.
- Throughput is one op per P+4 cycles minimum.
- `sub_mul` is combinational; its output is consumed in the same MULT cycle.
- No combinational path from `in_*` to `out_*`. `in_ready` decodes from state only.

## Structure
- Package `mul_pkg` holds:
  - `mul_op_e` (2-bit funct3[1:0] encoding).
  - `mul_state_e`.
  - Localparams N and N_W = N/2.
- Exactly one sub-module: `sub_mul` #(.mul_size(SUB_SIZE), .use_dsp(USE_DSP)), instantiated once.
- Chunk muxes, accumulator, negation and result select stay in `iter_mul`.

## Test plan
- MUL a=3, b=0xFFFF_FFFF_FFFF_FFFB -> `out_result`=0xFFFF_FFFF_FFFF_FFF1, `out_valid` first in cycle 19, tag echoed.
- MULH a=b=0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000. MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE.
- MULHSU a=0xFFFF_FFFF_FFFF_FFFF (-1), b=2 -> 0xFFFF_FFFF_FFFF_FFFF. MULH with the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- MULW a=0x1234_0000_7FFF_FFFF, b=2 -> 0xFFFF_FFFF_FFFF_FFFE, `out_valid` in cycle 7.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE -> `out_valid` stays 1, result and tag stable, `in_ready`=0. After the handshake, `in_ready`=1 the next cycle, and a back-to-back MUL 7×6 -> 42.
- Kill mid-operation:
  - Assert `flush` in cycle 8 of a MUL -> no `out_valid`, `in_ready`=1 in cycle 9, next MUL 5×5 -> 25.
  - Repeat with `rst` -> all outputs 0 in the cycle after `rst`, same recovery.
